// File: rtl/game_pkg.sv
// Shared game constants: game-state codes, raster limits, HP width and the
// hit-controller FSM encoding.
package game_pkg;

  localparam logic [3:0] ST_TITLE = 4'd0;
  localparam logic [3:0] ST_FIGHT = 4'd1;
  localparam logic [3:0] ST_MENU  = 4'd2;
  localparam logic [3:0] ST_OVER  = 4'd3;

  localparam logic [9:0] H_LAST = 10'd639;
  localparam logic [9:0] V_LAST = 10'd479;

  localparam int HP_W = 7;

  typedef enum logic [1:0] {
    HIT_OFF,
    HIT_ARMED,
    HIT_INVULN,
    HIT_DEAD
  } hit_state_e;

  function automatic logic is_eof(input logic [9:0] x, input logic [9:0] y);
    return (x == H_LAST) && (y == V_LAST);
  endfunction

endpackage

// File: rtl/heart_hit_ctrl_if.sv
// Sprite-flag and player-status bundle between the sprite blocks / game FSM
// (master) and heart_hit_ctrl (slave).
interface heart_hit_ctrl_if #(
  parameter int N_BULLETS = 3
);
  import game_pkg::*;

  logic [3:0]           state;
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 heart_on;
  logic [N_BULLETS-1:0] bullet_on;
  logic [N_BULLETS-1:0] collision;
  logic [HP_W-1:0]      hp;
  logic                 hit_pulse;
  logic                 invincible;
  logic                 game_over;

  modport master (
    output state, x, y, heart_on, bullet_on,
    input  collision, hp, hit_pulse, invincible, game_over
  );

  modport slave (
    input  state, x, y, heart_on, bullet_on,
    output collision, hp, hit_pulse, invincible, game_over
  );

endinterface

// File: rtl/frame_countdown.sv
// Loadable down-counter advanced by an end-of-frame strobe; flags zero and
// the last remaining frame so the owner can act on the expiring EOF.
module frame_countdown #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_zero,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
  assign o_last = (r_count == W'(1));

endmodule

// File: rtl/heart_hit_ctrl.sv
// Heart/bullet hit controller: per-frame overlap accumulation, sticky
// collision flags, HP, invincibility window and game-over.
// Optional build macro HEART_HIT_GODMODE_EN: hits are reported but HP never drops.
module heart_hit_ctrl
  import game_pkg::*;
#(
  parameter int         N_BULLETS     = 3,
  parameter int         HP_MAX        = 20,
  parameter int         DAMAGE        = 4,
  parameter int         INVULN_FRAMES = 30,
  parameter logic [3:0] FIGHT_STATE   = ST_FIGHT
) (
  input logic              clk,
  input logic              reset,
  heart_hit_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  hit_state_e           r_fsm;
  logic [N_BULLETS-1:0] r_acc;
  logic [N_BULLETS-1:0] r_collision;
  logic [HP_W-1:0]      r_hp;
  logic                 r_hit_pulse;
  logic                 r_invincible;
  logic                 r_game_over;

  logic                 w_eof;
  logic                 w_fight;
  logic [N_BULLETS-1:0] w_hits;
  logic                 w_hit;
  logic                 w_cnt_zero;
  logic                 w_cnt_last;
  logic                 w_expire;
  logic [HP_W-1:0]      w_hp_next;
  logic                 w_dead;

  assign w_eof   = is_eof(bus.x, bus.y);
  assign w_fight = (bus.state == FIGHT_STATE);
  // The EOF pixel itself still contributes to the frame being evaluated.
  assign w_hits  = r_acc | ({N_BULLETS{bus.heart_on}} & bus.bullet_on & ~r_collision);
  assign w_hit   = (r_fsm == HIT_ARMED) && w_fight && w_eof && (|w_hits);

`ifdef HEART_HIT_GODMODE_EN
  assign w_hp_next = r_hp;
  assign w_dead    = 1'b0;
`else
  // Saturate before subtracting so HP can never wrap.
  assign w_dead    = (r_hp <= HP_W'(DAMAGE));
  assign w_hp_next = w_dead ? '0 : r_hp - HP_W'(DAMAGE);
`endif

  frame_countdown #(.W(CNT_W)) u_invuln_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_hit),
    .i_load_val (CNT_W'(INVULN_FRAMES)),
    .i_tick     (w_eof),
    .o_zero     (w_cnt_zero),
    .o_last     (w_cnt_last)
  );

  assign w_expire = w_eof && (w_cnt_last || w_cnt_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm        <= HIT_OFF;
      r_acc        <= '0;
      r_collision  <= '0;
      r_hp         <= HP_W'(HP_MAX);
      r_hit_pulse  <= 1'b0;
      r_invincible <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      r_acc       <= '0;

      if (!w_fight) begin
        r_collision <= '0;
      end else if (w_hit) begin
        r_collision <= r_collision | w_hits;
      end

      case (r_fsm)
        HIT_OFF: begin
          if (w_fight) r_fsm <= HIT_ARMED;
        end
        HIT_ARMED: begin
          if (!w_fight) begin
            r_fsm <= HIT_OFF;
          end else if (w_eof) begin
            if (|w_hits) begin
              r_hit_pulse <= 1'b1;
              r_hp        <= w_hp_next;
              if (w_dead) begin
                r_fsm       <= HIT_DEAD;
                r_game_over <= 1'b1;
              end else begin
                r_fsm        <= HIT_INVULN;
                r_invincible <= 1'b1;
              end
            end
          end else begin
            r_acc <= w_hits;
          end
        end
        HIT_INVULN: begin
          if (w_expire) begin
            r_invincible <= 1'b0;
            r_fsm        <= w_fight ? HIT_ARMED : HIT_OFF;
          end
        end
        HIT_DEAD: begin
          r_fsm <= HIT_DEAD;
        end
        default: r_fsm <= HIT_OFF;
      endcase
    end
  end

  assign bus.collision  = r_collision;
  assign bus.hp         = r_hp;
  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.invincible = r_invincible;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_heart_hit_ctrl.sv
// Directed-vector bench for heart_hit_ctrl; frames are compressed to a few
// pixels followed by the (639,479) end-of-frame pixel.
module tb_heart_hit_ctrl;
  import game_pkg::*;

  localparam int NB = 3;
`ifdef HEART_HIT_GODMODE_EN
  localparam bit GOD = 1'b1;
`else
  localparam bit GOD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    st;
  logic [3:0]    st_b;
  logic [9:0]    px;
  logic [9:0]    py;
  logic          heart;
  logic [NB-1:0] bul;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int p0;

  always #5 clk = ~clk;

  heart_hit_ctrl_if #(.N_BULLETS(NB)) if_a ();
  heart_hit_ctrl_if #(.N_BULLETS(NB)) if_b ();

  assign if_a.state     = st;
  assign if_a.x         = px;
  assign if_a.y         = py;
  assign if_a.heart_on  = heart;
  assign if_a.bullet_on = bul;
  assign if_b.state     = st_b;
  assign if_b.x         = px;
  assign if_b.y         = py;
  assign if_b.heart_on  = heart;
  assign if_b.bullet_on = bul;

  heart_hit_ctrl #(.N_BULLETS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  heart_hit_ctrl #(.N_BULLETS(NB), .HP_MAX(6), .DAMAGE(4), .INVULN_FRAMES(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always @(negedge clk) if (if_a.hit_pulse === 1'b1) pulse_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xx, input int yy, input logic h, input logic [NB-1:0] b);
    px    = 10'(xx);
    py    = 10'(yy);
    heart = h;
    bul   = b;
  endtask

  // n_ov overlapping pixels, one idle pixel, then the EOF pixel; leaves the
  // first pixel of the next frame driven but not yet clocked.
  task automatic run_frame(input logic [NB-1:0] b, input int n_ov);
    for (int i = 0; i < n_ov; i++) begin
      drive(100 + i, 100, 1'b1, b);
      tick();
    end
    drive(0, 200, 1'b0, '0);
    tick();
    drive(639, 479, 1'b0, '0);
    tick();
    drive(0, 0, 1'b0, '0);
  endtask

  task automatic wait_invuln(input int n);
    st = ST_TITLE;
    drive(0, 10, 1'b0, '0);
    tick();
    st = ST_FIGHT;
    repeat (n) run_frame('0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    st    = ST_TITLE;
    st_b  = ST_TITLE;
    drive(0, 0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (if_a.collision !== 3'b000) begin n_err++; $display("FAIL reset_collision: got %b expected 000", if_a.collision); end
    n_vec++; if (if_a.hp !== 7'd20) begin n_err++; $display("FAIL reset_hp: got %0d expected 20", if_a.hp); end
    n_vec++; if (if_a.hit_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b expected 0", if_a.hit_pulse); end
    n_vec++; if (if_a.invincible !== 1'b0) begin n_err++; $display("FAIL reset_invincible: got %b expected 0", if_a.invincible); end
    n_vec++; if (if_a.game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b expected 0", if_a.game_over); end
    n_vec++; if (if_b.hp !== 7'd6) begin n_err++; $display("FAIL reset_hp_b: got %0d expected 6", if_b.hp); end
  endtask

  task automatic test_single_hit();
    st = ST_FIGHT;
    tick();
    p0 = pulse_cnt;
    run_frame(3'b001, 16);
    n_vec++; if (if_a.collision !== 3'b001) begin n_err++; $display("FAIL hit_collision: got %b expected 001", if_a.collision); end
    n_vec++; if (if_a.hp !== (GOD ? 7'd20 : 7'd16)) begin n_err++; $display("FAIL hit_hp: got %0d expected %0d", if_a.hp, GOD ? 20 : 16); end
    n_vec++; if (if_a.hit_pulse !== 1'b1) begin n_err++; $display("FAIL hit_pulse_high: got %b expected 1", if_a.hit_pulse); end
    n_vec++; if (if_a.invincible !== 1'b1) begin n_err++; $display("FAIL hit_invincible: got %b expected 1", if_a.invincible); end
    tick();
    n_vec++; if (if_a.hit_pulse !== 1'b0) begin n_err++; $display("FAIL hit_pulse_low: got %b expected 0", if_a.hit_pulse); end
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL hit_pulse_count: got %0d expected 1", pulse_cnt - p0); end
  endtask

  task automatic test_invuln();
    p0 = pulse_cnt;
    for (int f = 1; f <= 30; f++) begin
      run_frame(3'b011, 16);
      if (f == 29) begin
        n_vec++; if (if_a.invincible !== 1'b1) begin n_err++; $display("FAIL inv_frame29: got %b expected 1", if_a.invincible); end
      end
    end
    n_vec++; if (if_a.invincible !== 1'b0) begin n_err++; $display("FAIL inv_expired: got %b expected 0", if_a.invincible); end
    n_vec++; if (if_a.hp !== (GOD ? 7'd20 : 7'd16)) begin n_err++; $display("FAIL inv_hp: got %0d expected %0d", if_a.hp, GOD ? 20 : 16); end
    n_vec++; if (if_a.collision !== 3'b001) begin n_err++; $display("FAIL inv_collision: got %b expected 001", if_a.collision); end
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL inv_no_pulse: got %0d expected 0", pulse_cnt - p0); end
    run_frame(3'b010, 4);
    n_vec++; if (if_a.collision !== 3'b011) begin n_err++; $display("FAIL rehit_collision: got %b expected 011", if_a.collision); end
    n_vec++; if (if_a.hp !== (GOD ? 7'd20 : 7'd12)) begin n_err++; $display("FAIL rehit_hp: got %0d expected %0d", if_a.hp, GOD ? 20 : 12); end
    tick();
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL rehit_pulse_count: got %0d expected 1", pulse_cnt - p0); end
  endtask

  task automatic test_leave_fight();
    p0 = pulse_cnt;
    st = ST_MENU;
    drive(50, 50, 1'b1, 3'b111);
    tick();
    n_vec++; if (if_a.collision !== 3'b000) begin n_err++; $display("FAIL leave_collision_clear: got %b expected 000", if_a.collision); end
    for (int f = 0; f < 30; f++) run_frame(3'b111, 8);
    n_vec++; if (if_a.invincible !== 1'b0) begin n_err++; $display("FAIL leave_inv_expired: got %b expected 0", if_a.invincible); end
    run_frame(3'b111, 8);
    n_vec++; if (if_a.hp !== (GOD ? 7'd20 : 7'd12)) begin n_err++; $display("FAIL leave_hp: got %0d expected %0d", if_a.hp, GOD ? 20 : 12); end
    n_vec++; if (if_a.collision !== 3'b000) begin n_err++; $display("FAIL leave_collision: got %b expected 000", if_a.collision); end
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL leave_no_pulse: got %0d expected 0", pulse_cnt - p0); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    st = ST_FIGHT;
    tick();
    p0 = pulse_cnt;
    run_frame(3'b101, 8);
    n_vec++; if (if_a.collision !== 3'b101) begin n_err++; $display("FAIL simul_collision: got %b expected 101", if_a.collision); end
    n_vec++; if (if_a.hp !== (GOD ? 7'd20 : 7'd16)) begin n_err++; $display("FAIL simul_hp: got %0d expected %0d", if_a.hp, GOD ? 20 : 16); end
    tick();
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL simul_pulse_count: got %0d expected 1", pulse_cnt - p0); end
    n_vec++; if (if_a.collision !== 3'b101) begin n_err++; $display("FAIL simul_sticky: got %b expected 101", if_a.collision); end
  endtask

  task automatic test_game_over();
    logic [6:0] exp_hp;
    logic       exp_go;
    do_reset();
    st = ST_FIGHT;
    tick();
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_invuln(30);
      run_frame(3'b001, 4);
      exp_hp = GOD ? 7'd20 : 7'(16 - 4 * k);
      exp_go = (!GOD) && (k == 4);
      n_vec++; if (if_a.hp !== exp_hp) begin n_err++; $display("FAIL go_hp_%0d: got %0d expected %0d", k, if_a.hp, exp_hp); end
      n_vec++; if (if_a.game_over !== exp_go) begin n_err++; $display("FAIL go_flag_%0d: got %b expected %b", k, if_a.game_over, exp_go); end
    end
    tick();
    n_vec++; if (pulse_cnt - p0 !== 5) begin n_err++; $display("FAIL go_pulse_count: got %0d expected 5", pulse_cnt - p0); end
    p0 = pulse_cnt;
    st = ST_TITLE;
    tick();
    st = ST_FIGHT;
    run_frame(3'b010, 4);
    tick();
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL dead_no_pulse: got %0d expected 0", pulse_cnt - p0); end
    n_vec++; if (if_a.hp !== (GOD ? 7'd20 : 7'd0)) begin n_err++; $display("FAIL dead_hp: got %0d expected %0d", if_a.hp, GOD ? 20 : 0); end
    n_vec++; if (if_a.collision !== 3'b000) begin n_err++; $display("FAIL dead_collision: got %b expected 000", if_a.collision); end
    do_reset();
    n_vec++; if (if_a.hp !== 7'd20) begin n_err++; $display("FAIL revive_hp: got %0d expected 20", if_a.hp); end
    n_vec++; if (if_a.game_over !== 1'b0) begin n_err++; $display("FAIL revive_game_over: got %b expected 0", if_a.game_over); end
  endtask

  task automatic test_saturate();
    st   = ST_TITLE;
    st_b = ST_FIGHT;
    tick();
    run_frame(3'b001, 4);
    n_vec++; if (if_b.hp !== (GOD ? 7'd6 : 7'd2)) begin n_err++; $display("FAIL sat_hp_first: got %0d expected %0d", if_b.hp, GOD ? 6 : 2); end
    st_b = ST_TITLE;
    tick();
    st_b = ST_FIGHT;
    repeat (2) run_frame('0, 0);
    run_frame(3'b001, 4);
    n_vec++; if (if_b.hp !== (GOD ? 7'd6 : 7'd0)) begin n_err++; $display("FAIL sat_hp_zero: got %0d expected %0d", if_b.hp, GOD ? 6 : 0); end
    n_vec++; if (if_b.game_over !== (GOD ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL sat_game_over: got %b expected %b", if_b.game_over, !GOD); end
    n_vec++; if (if_a.hp !== 7'd20) begin n_err++; $display("FAIL sat_main_untouched: got %0d expected 20", if_a.hp); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_invuln();
    test_leave_fight();
    test_simultaneous();
    test_game_over();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/heart_hit_ctrl.md
Name: heart_hit_ctrl

Overview:
- Consumes the per-pixel sprite-on flags driven by the bullet sprite blocks and the heart sprite.
- Detects heart/bullet overlap within each frame and returns the per-bullet `collision` signal that the bullet blocks use to retire themselves.
- Owns player HP, post-hit invincibility frames and the game-over flag.
- Sits between the bullet sprite instances and the top-level game state machine.

Parameters:
- N_BULLETS, 3, number of bullet sprite inputs and collision outputs
- HP_MAX, 20, HP loaded on reset
- DAMAGE, 4, HP removed per accepted hit
- INVULN_FRAMES, 30, frames of invincibility after an accepted hit
- FIGHT_STATE, 4'd1, game-state code in which collisions are evaluated

Ports:
- clk  in  1  pixel clock, same as the sprite blocks
- reset  in  1  synchronous, active-high
- state  in  4  game state from the top-level FSM
- x  in  10  current pixel column, 0..639
- y  in  10  current pixel row, 0..479
- heart_on  in  1  heart sprite covers the current pixel
- bullet_on  in  N_BULLETS  bit i: bullet i covers the current pixel
- collision  out  N_BULLETS  bit i: bullet i has hit the heart (sticky)
- hp  out  7  current HP, unsigned
- hit_pulse  out  1  one-cycle strobe per accepted hit
- invincible  out  1  high while the invincibility window is active
- game_over  out  1  sticky once HP reaches 0

Behaviour:
- Reset: collision=0, hp=HP_MAX, hit_pulse=0, invincible=0, game_over=0, acc=0, FSM=OFF, invuln counter=0. Reset mid-frame discards any partial accumulation.
- End of frame (EOF) is the cycle where x==639 and y==479.
- Overlap accumulator acc[N_BULLETS-1:0]:
  - Each cycle in ARMED: acc[i] |= heart_on & bullet_on[i] & ~collision[i].
  - In any other state acc holds 0.
  - acc clears at every EOF, after it has been evaluated.
- FSM states and transitions:
  - OFF → ARMED when state==FIGHT_STATE.
  - ARMED → OFF when state!=FIGHT_STATE.
  - ARMED, at EOF with acc!=0:
    - collision <= collision | acc
    - hp <= hp − DAMAGE, saturating at 0
    - hit_pulse=1 for exactly the next cycle
    - counter <= INVULN_FRAMES
    - next state = DEAD if the new hp is 0, else INVULN
  - INVULN: invincible=1; counter decrements at each EOF; → ARMED (or OFF if state!=FIGHT_STATE) at the EOF where the counter reaches 0. No accumulation, so bullets overlapping the heart in this window are not consumed.
  - DEAD: game_over=1. Only reset leaves DEAD. acc frozen at 0.
- collision:
  - Cleared the cycle after state!=FIGHT_STATE is seen, in any FSM state.
  - Otherwise bits only set, never cleared. This matches the bullet-block retire rule.
- Latency: a collision registered at EOF is visible on the first pixel of the next frame, before any bullet position update in that frame.
- Simultaneous hits: several acc bits set at the same EOF count as one hit (one DAMAGE, one pulse), but all those collision bits are set.
- Leaving fight state while in INVULN: the counter keeps running on EOFs. The FSM goes to OFF when the counter expires.
- hp arithmetic: 7-bit unsigned. Compare hp<=DAMAGE first to saturate, so there is no wrap-around.
- Heart/bullet sprite-on inputs are registered by their producers. This block adds no extra alignment.

Optional Feature:
- Macro: HEART_HIT_GODMODE_EN.
- Defined: hits are still detected; collision bits still set; hit_pulse and the invincibility window are still generated. hp never changes and game_over stays 0, so the DEAD state is unreachable.
- Undefined: full behaviour as above.

Decomposition:
- Shared package `game_pkg`:
  - game-state codes (FIGHT_STATE etc.)
  - H_LAST=639, V_LAST=479
  - FSM state encoding for OFF/ARMED/INVULN/DEAD
  - HP width constant (7)
- Sub-module `frame_countdown`: loadable down-counter advanced on EOF strobe, with a zero flag. It implements the invincibility timer.

Test Plan:
- Reset, state=1, heart and bullet0 overlap for 16 pixels in frame 0 → at EOF collision=3'b001, hp 20→16, hit_pulse high exactly 1 cycle, invincible=1.
- After that hit, the same overlap repeats in frames 1..30 → hp stays 16, collision unchanged. After 30 EOFs invincible=0 and a new bullet1 overlap at EOF → collision=3'b011, hp=12.
- Bullets 0 and 2 overlap the heart in the same frame → collision=3'b101, hp 20→16, only one hit_pulse.
- Five accepted hits spaced beyond invincibility → hp=0, game_over=1. A further overlap → no pulse, hp stays 0. Reset → hp=20, game_over=0.
- hp=2 with DAMAGE=4 → hp saturates to 0, not 126.
- Hit latched, then state changes 1→2 mid-frame → collision=0 next cycle. Overlap while state=2 → no hp change. Build with HEART_HIT_GODMODE_EN, hit → collision set, hp stays 20.
